// File: rtl/uart_pkg.sv
// Shared UART constants: data width, RX FIFO depth, APB register map and STATUS bit layout.
package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int UART_RX_FIFO_DEPTH = 16;

  typedef enum logic [11:0] {
    UART_REG_RXDATA = 12'h000,
    UART_REG_STATUS = 12'h004,
    UART_REG_CTRL   = 12'h008
  } uart_reg_e;

  localparam int UART_STATUS_EMPTY_BIT   = 0;
  localparam int UART_STATUS_FULL_BIT    = 1;
  localparam int UART_STATUS_OVERRUN_BIT = 2;
  localparam int UART_STATUS_LEVEL_LSB   = 8;

  // Packs the RX FIFO flags into the STATUS register image.
  function automatic logic [31:0] uart_status_word(input logic empty, input logic full,
                                                   input logic overrun, input logic [7:0] level);
    logic [31:0] word;
    word = 32'h0000_0000;
    word[UART_STATUS_EMPTY_BIT]   = empty;
    word[UART_STATUS_FULL_BIT]    = full;
    word[UART_STATUS_OVERRUN_BIT] = overrun;
    word[UART_STATUS_LEVEL_LSB +: 8] = level;
    return word;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-push / APB-pop bundle of the RX FIFO; master drives requests, slave is the FIFO.
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = UART_RX_FIFO_DEPTH
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              flush;
  logic              rx_done;
  logic [DATA_W-1:0] rx_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   level;
  logic              overrun;
  logic              clr_overrun;

  modport master (
    output flush, rx_done, rx_data, rd_en, clr_overrun,
    input  rd_data, rd_valid, empty, full, level, overrun
  );

  modport slave (
    input  flush, rx_done, rx_data, rd_en, clr_overrun,
    output rd_data, rd_valid, empty, full, level, overrun
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between the UART receiver and the APB register file.
// One push per rx_done rising edge, registered pop data, sticky overrun on dropped bytes.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = UART_RX_FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_fifo_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   level_r;
  logic              empty_r;
  logic              full_r;
  logic              overrun_r;
  logic              rx_done_q_r;
  logic [DATA_W-1:0] rd_data_r;
  logic              rd_valid_r;

  logic              push_req_s;
  logic              pop_ok_s;
  logic              push_ok_s;
  logic              drop_s;
  logic [ADDR_W:0]   level_nxt_s;

  // Accept/drop decisions and next fill level; a full FIFO still takes a byte if a pop frees a slot.
  always_comb begin
    push_req_s  = 1'b0;
    pop_ok_s    = 1'b0;
    push_ok_s   = 1'b0;
    drop_s      = 1'b0;
    level_nxt_s = level_r;
    push_req_s  = bus.rx_done & ~rx_done_q_r;
    pop_ok_s    = bus.rd_en & ~empty_r & ~bus.flush;
    push_ok_s   = push_req_s & ~bus.flush & (~full_r | pop_ok_s);
    drop_s      = push_req_s & ~bus.flush & full_r & ~pop_ok_s;
    if (bus.flush) begin
      level_nxt_s = {(ADDR_W+1){1'b0}};
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_nxt_s = level_r + (ADDR_W+1)'(1);
        2'b01:   level_nxt_s = level_r - (ADDR_W+1)'(1);
        default: level_nxt_s = level_r;
      endcase
    end
  end

  // Pointers, fill level, flags, edge register and registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= {ADDR_W{1'b0}};
      rd_ptr_r    <= {ADDR_W{1'b0}};
      level_r     <= {(ADDR_W+1){1'b0}};
      empty_r     <= 1'b1;
      full_r      <= 1'b0;
      overrun_r   <= 1'b0;
      rx_done_q_r <= 1'b0;
      rd_data_r   <= {DATA_W{1'b0}};
      rd_valid_r  <= 1'b0;
    end else begin
      rx_done_q_r <= bus.rx_done;
      level_r     <= level_nxt_s;
      empty_r     <= (level_nxt_s == {(ADDR_W+1){1'b0}});
      full_r      <= (level_nxt_s == LEVEL_FULL);
      rd_valid_r  <= pop_ok_s;
      if (bus.flush) begin
        wr_ptr_r <= {ADDR_W{1'b0}};
        rd_ptr_r <= {ADDR_W{1'b0}};
      end else begin
        if (push_ok_s) begin
          wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
        end
        if (pop_ok_s) begin
          rd_ptr_r  <= rd_ptr_r + ADDR_W'(1);
          rd_data_r <= mem_r[rd_ptr_r];
        end
      end
      // Set dominates a same-cycle clear so a drop is never lost.
      if (drop_s) begin
        overrun_r <= 1'b1;
      end else if (bus.clr_overrun) begin
        overrun_r <= 1'b0;
      end
    end
  end

  // Storage write; contents are never observable while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= bus.rx_data;
    end
  end

  assign bus.rd_data  = rd_data_r;
  assign bus.rd_valid = rd_valid_r;
  assign bus.empty    = empty_r;
  assign bus.full     = full_r;
  assign bus.level    = level_r;
  assign bus.overrun  = overrun_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: vector table for simple sequences, loops for fill/drain/wrap.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  typedef struct {
    string      tag;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       rd_en;
    logic [4:0] exp_level;
    logic       exp_empty;
    logic       exp_full;
    logic       exp_ovr;
    logic       exp_rv;
    logic [7:0] exp_rd;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  vec_t vecs[$];

  uart_rx_fifo_if #(.DATA_W(8), .DEPTH(16)) bus ();

  uart_rx_fifo #(.DATA_W(8), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [4:0] lvl, input logic emp, input logic ful,
                         input logic ovr, input logic rv, input logic [7:0] rd);
    chk({nm, ".level"},    32'(bus.level),    32'(lvl));
    chk({nm, ".empty"},    32'(bus.empty),    32'(emp));
    chk({nm, ".full"},     32'(bus.full),     32'(ful));
    chk({nm, ".overrun"},  32'(bus.overrun),  32'(ovr));
    chk({nm, ".rd_valid"}, 32'(bus.rd_valid), 32'(rv));
    chk({nm, ".rd_data"},  32'(bus.rd_data),  32'(rd));
  endtask

  // Drive inputs on the falling edge, let one rising edge pass, return on the next falling edge.
  task automatic step(input logic rd, input logic [7:0] d, input logic re,
                      input logic fl, input logic clr, input logic rs);
    bus.rx_done     = rd;
    bus.rx_data     = d;
    bus.rd_en       = re;
    bus.flush       = fl;
    bus.clr_overrun = clr;
    rst             = rs;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input string t, input logic rd, input logic [7:0] d, input logic re,
                     input logic [4:0] l, input logic e, input logic f, input logic o,
                     input logic v, input logic [7:0] q);
    vec_t x;
    x.tag = t; x.rx_done = rd; x.rx_data = d; x.rd_en = re;
    x.exp_level = l; x.exp_empty = e; x.exp_full = f; x.exp_ovr = o; x.exp_rv = v; x.exp_rd = q;
    vecs.push_back(x);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.rx_done = 1'b0; bus.rx_data = 8'h00; bus.rd_en = 1'b0;
    bus.flush = 1'b0; bus.clr_overrun = 1'b0; rst = 1'b1;

    for (int i = 0; i < 10; i++) add("idle", 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++)  add("hold", 1'b1, 8'hA5, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    add("fall",       1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    add("pop_a5",     1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5);
    add("after_pop",  1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
    add("pop_empty",  1'b0, 8'h11, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
    add("push_pop_e", 1'b1, 8'h3C, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);
    add("fall2",      1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);
    add("pop_3c",     1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C);

    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_all("reset", 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    foreach (vecs[i]) begin
      step(vecs[i].rx_done, vecs[i].rx_data, vecs[i].rd_en, 1'b0, 1'b0, 1'b0);
      chk_all($sformatf("vec%0d_%s", i, vecs[i].tag), vecs[i].exp_level, vecs[i].exp_empty,
              vecs[i].exp_full, vecs[i].exp_ovr, vecs[i].exp_rv, vecs[i].exp_rd);
    end

    // Fill, overflow by one, drain in order.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("fill%0d.level", i), 32'(bus.level), 32'(i + 1));
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("full.full", 32'(bus.full), 32'd1);
    step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_all("drop_ff", 5'd16, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      chk_all($sformatf("drain%0d", i), 5'(15 - i), (i == 15), 1'b0, 1'b1, 1'b1, 8'(i));
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("drain_extra", 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h0F);

    // Flush keeps overrun and rd_data; clr_overrun clears; reset mid-fill.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("pre_flush.level", 32'(bus.level), 32'd3);
    step(1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_all("flush", 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h0F);
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush_edge_lost.level", 32'(bus.level), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_all("clr_ovr", 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0F);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("pop_50", 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 8'h50);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_all("rst_mid", 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    // Simultaneous push+pop while full, then pointer wrap.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("full_pushpop", 5'd16, 1'b0, 1'b1, 1'b0, 1'b1, 8'h20);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("drain_b%0d.rd_data", i), 32'(bus.rd_data), 32'(8'h20 + 8'(i)));
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("last_55", 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55);
    step(1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, 8'h80 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("wrap%0d.rd_data", i), 32'(bus.rd_data), 32'(8'h80 + 8'(i - 1)));
      chk($sformatf("wrap%0d.level", i), 32'(bus.level), 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("wrap_end", 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
